// File: rtl/lcd_scan.sv
// Four-digit common-anode scan driver showing "H.L E X" from a frame-latched word.
// Leading-zero and anti-ghost blanking; all pins registered.
module lcd_scan #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lcd_val,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [11:0]   shadow;
  logic          wrap;
  logic          blank;
  logic [3:0]    nib;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign wrap = (div == DIV_LAST);

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (div < DW'(BLANK_CYC));
    end
  endgenerate

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    nib   = shadow[3:0];
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    unique case (idx)
      2'd0: begin
        an_d  = 4'b0111;
        nib   = shadow[11:8];
        seg_d = (lz_en && nib == 4'd0) ? 7'b1111111 : dec(nib);
        dp_d  = 1'b0;
      end
      2'd1: begin
        an_d  = 4'b1011;
        nib   = shadow[7:4];
        seg_d = dec(nib);
      end
      2'd2: begin
        an_d  = 4'b1101;
        seg_d = 7'b0000110;
      end
      2'd3: begin
        an_d  = 4'b1110;
        nib   = shadow[3:0];
        seg_d = dec(nib);
      end
    endcase
    // Dark window at the start of each slot hides the previous digit's decay
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      idx    <= '0;
      shadow <= '0;
      an     <= 4'b1111;
      seg    <= 7'b1111111;
      dp     <= 1'b1;
      frame  <= 1'b0;
    end else begin
      frame <= wrap && (idx == 2'd3);
      if (wrap) begin
        div <= '0;
        idx <= idx + 2'd1;
        if (idx == 2'd3) shadow <= lcd_val;
      end else begin
        div <= div + 1'b1;
      end
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_lcd_scan.sv
// Bench for lcd_scan: scoreboarded frame contents plus timing of
// reset, blanking and back-to-back capture on three parameterisations.
module tb_lcd_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lcd_val = 12'h000;
  logic        lz_en = 1'b0;

  logic [3:0] an4, an8, an2;
  logic [6:0] seg4, seg8, seg2;
  logic       dp4, dp8, dp2;
  logic       frame4, frame8, frame2;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  logic [3:0] obs_an  [16];
  logic [6:0] obs_seg [16];
  logic       obs_dp  [16];
  logic       obs_fr  [16];

  always #5 clk = ~clk;

  lcd_scan #(.CLK_DIV(4), .BLANK_CYC(1)) u4 (
    .clk(clk), .rst(rst), .lcd_val(lcd_val), .lz_en(lz_en),
    .an(an4), .seg(seg4), .dp(dp4), .frame(frame4)
  );

  lcd_scan #(.CLK_DIV(8), .BLANK_CYC(3)) u8 (
    .clk(clk), .rst(rst), .lcd_val(lcd_val), .lz_en(lz_en),
    .an(an8), .seg(seg8), .dp(dp8), .frame(frame8)
  );

  lcd_scan #(.CLK_DIV(2), .BLANK_CYC(0)) u2 (
    .clk(clk), .rst(rst), .lcd_val(lcd_val), .lz_en(lz_en),
    .an(an2), .seg(seg2), .dp(dp2), .frame(frame2)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  task automatic push_frame(input logic [11:0] v, input logic lz);
    exp_t e;
    e.an = 4'b0111; e.dp = 1'b0;
    e.seg = (lz && v[11:8] == 4'd0) ? 7'h7F : seg_of(v[11:8]);
    exp_q.push_back(e);
    e.an = 4'b1011; e.dp = 1'b1; e.seg = seg_of(v[7:4]);
    exp_q.push_back(e);
    e.an = 4'b1101; e.seg = 7'b0000110;
    exp_q.push_back(e);
    e.an = 4'b1110; e.seg = seg_of(v[3:0]);
    exp_q.push_back(e);
  endtask

  // Call at the negedge right after a u4 capture edge; returns aligned
  // on the negedge after the next capture edge.
  task automatic collect_frame(input int chg_k, input logic [11:0] chg_val);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      obs_an[k]  = an4;
      obs_seg[k] = seg4;
      obs_dp[k]  = dp4;
      obs_fr[k]  = frame4;
      if (k == chg_k) begin
        lcd_val = chg_val;
        push_frame(chg_val, lz_en);
      end
    end
  endtask

  task automatic test_reset();
    int first;
    int n;
    lcd_val = 12'h473;
    lz_en   = 1'b0;
    push_frame(12'h473, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (an4 !== 4'b1111 || seg4 !== 7'h7F || dp4 !== 1'b1 || frame4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: an=%b seg=%b dp=%b fr=%b want 1111 1111111 1 0",
                 i, an4, seg4, dp4, frame4);
      end
    end
    rst = 1'b0;
    first = 0;
    n = 0;
    while (first == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (an4 !== 4'b1111) begin
          errors++;
          $display("FAIL first_div0: an=%b want 1111", an4);
        end
      end
      if (n == 2) begin
        checks++;
        if (an4 !== 4'b0111 || seg4 !== 7'b1000000) begin
          errors++;
          $display("FAIL first_active: an=%b seg=%b want 0111 1000000", an4, seg4);
        end
      end
      if (frame4 === 1'b1) first = n;
    end
    checks++;
    if (first != 16) begin
      errors++;
      $display("FAIL first_frame: got cycle %0d want 16", first);
    end
  endtask

  task automatic test_normal();
    exp_t e;
    int cnt;
    int pulses;
    collect_frame(-1, 12'h000);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL normal_queue slot %0d: empty want entry", s);
        continue;
      end
      e = exp_q.pop_front();
      if (obs_an[4*s] !== 4'b1111 || obs_seg[4*s] !== 7'h7F) begin
        errors++;
        $display("FAIL normal_blank slot %0d: an=%b seg=%b want 1111 1111111",
                 s, obs_an[4*s], obs_seg[4*s]);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if ({obs_an[4*s+k], obs_seg[4*s+k], obs_dp[4*s+k]} !== e) begin
          errors++;
          $display("FAIL normal_slot %0d cyc %0d: an=%b seg=%b dp=%b want %b %b %b",
                   s, k, obs_an[4*s+k], obs_seg[4*s+k], obs_dp[4*s+k], e.an, e.seg, e.dp);
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) if (obs_an[k][b] === 1'b0) cnt++;
      checks++;
      if (cnt != 3) begin
        errors++;
        $display("FAIL anode_cycles an[%0d]: got %0d want 3", b, cnt);
      end
    end
    pulses = 0;
    for (int k = 0; k < 15; k++) if (obs_fr[k] !== 1'b0) pulses++;
    checks++;
    if (pulses != 0 || obs_fr[15] !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: early=%0d end=%b want 0 1", pulses, obs_fr[15]);
    end
  endtask

  task automatic test_lz_invalid();
    exp_t e;
    lcd_val = 12'h0A1;
    lz_en   = 1'b1;
    push_frame(12'h473, 1'b1);
    push_frame(12'h0A1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        lz_en = 1'b0;
        push_frame(12'h0A1, 1'b0);
      end
      collect_frame(-1, 12'h000);
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL lz_queue frame %0d slot %0d: empty want entry", f, s);
          continue;
        end
        e = exp_q.pop_front();
        if ({obs_an[4*s+2], obs_seg[4*s+2], obs_dp[4*s+2]} !== e) begin
          errors++;
          $display("FAIL lz_slot f%0d s%0d: an=%b seg=%b dp=%b want %b %b %b",
                   f, s, obs_an[4*s+2], obs_seg[4*s+2], obs_dp[4*s+2], e.an, e.seg, e.dp);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    exp_t e;
    push_frame(12'h0A1, 1'b0);
    lcd_val = 12'h123;
    push_frame(12'h123, 1'b0);
    for (int f = 0; f < 3; f++) begin
      collect_frame((f == 1) ? 5 : -1, 12'h456);
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tear_queue frame %0d slot %0d: empty want entry", f, s);
          continue;
        end
        e = exp_q.pop_front();
        for (int k = 1; k < 4; k++) begin
          if ({obs_an[4*s+k], obs_seg[4*s+k], obs_dp[4*s+k]} !== e) begin
            errors++;
            $display("FAIL tear_slot f%0d s%0d c%0d: an=%b seg=%b want %b %b",
                     f, s, k, obs_an[4*s+k], obs_seg[4*s+k], e.an, e.seg);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int first;
    int early;
    int n;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an4 !== 4'b1111 || seg4 !== 7'h7F || dp4 !== 1'b1 || frame4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%b seg=%b dp=%b fr=%b want 1111 1111111 1 0",
               an4, seg4, dp4, frame4);
    end
    rst = 1'b0;
    first = 0;
    early = 0;
    n = 0;
    while (first == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (frame4 === 1'b1) first = n;
    end
    checks++;
    if (first != 16) begin
      errors++;
      $display("FAIL mid_reset_frame: got cycle %0d want 16", first);
    end
  endtask

  task automatic test_anti_ghost();
    int n;
    int d;
    int s;
    logic [3:0] ea;
    n = 0;
    while (frame8 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame8 !== 1'b1) begin
      errors++;
      $display("FAIL ghost_wait: frame=%b want 1", frame8);
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      d = (k - 1) % 8;
      s = ((k - 1) / 8) % 4;
      ea = 4'b1000;
      ea = ~(ea >> s);
      checks++;
      if (d < 3) begin
        if (an8 !== 4'b1111 || seg8 !== 7'h7F) begin
          errors++;
          $display("FAIL ghost_blank k%0d: an=%b seg=%b want 1111 1111111", k, an8, seg8);
        end
      end else if (an8 !== ea) begin
        errors++;
        $display("FAIL ghost_active k%0d: an=%b want %b", k, an8, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic ef;
    n = 0;
    while (frame2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame2 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wait: frame=%b want 1", frame2);
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      ef = (k % 8 == 0);
      checks++;
      if (frame2 !== ef) begin
        errors++;
        $display("FAIL b2b_frame k%0d: frame=%b want %b", k, frame2, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_lz_invalid();
    test_tear_free();
    test_mid_reset();
    test_anti_ghost();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
